// File: rtl/ula_pkg.sv
// ula_pkg: shared types for the shared-ALU sequencer.
// ALU op codes, controller states, op legality helper.
package ula_pkg;

  typedef logic [3:0] ula_op_t;

  localparam ula_op_t OP_ADD = 4'd0;
  localparam ula_op_t OP_SUB = 4'd1;
  localparam ula_op_t OP_AND = 4'd2;
  localparam ula_op_t OP_OR  = 4'd3;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    HOLD = 2'd2
  } state_t;

  function automatic logic op_is_legal(ula_op_t op);
    return op <= OP_OR;
  endfunction

endpackage

// File: rtl/ula.sv
// ula: 8-bit ALU, op 0 add, 1 sub, 2 and, 3 or, others 0.
// Ports: op, a, b in; y out (combinational, modulo 256).
module ula
  import ula_pkg::*;
(
  input  ula_op_t    op,
  input  logic [7:0] a,
  input  logic [7:0] b,
  output logic [7:0] y
);

  always_comb begin
    y = 8'h00;
    unique case (op)
      OP_ADD:  y = a + b;
      OP_SUB:  y = a - b;
      OP_AND:  y = a & b;
      OP_OR:   y = a | b;
      default: y = 8'h00;
    endcase
  end

endmodule

// File: rtl/ula_rr_arb.sv
// ula_rr_arb: combinational round-robin pick among req.
// Ports: req, ptr in; one-hot gnt and encoded idx out.
module ula_rr_arb #(
  parameter int NREQ = 2,
  localparam int IDW = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] req,
  input  logic [IDW-1:0]  ptr,
  output logic [NREQ-1:0] gnt,
  output logic [IDW-1:0]  idx
);

  logic found;
  int   c;

  // Walk from ptr upward, wrapping, first set bit wins.
  always_comb begin
    gnt   = '0;
    idx   = '0;
    found = 1'b0;
    c     = 0;
    for (int k = 0; k < NREQ; k++) begin
      c = (int'(ptr) + k) % NREQ;
      if (!found && req[c]) begin
        found  = 1'b1;
        gnt[c] = 1'b1;
        idx    = IDW'(c);
      end
    end
  end

endmodule

// File: rtl/ula_share_ctrl.sv
// ula_share_ctrl: round-robin sharing of one ula among NREQ
// requesters. Ports: clk, rst (sync, high); req_valid/ready
// with packed req_op/a/b; rsp_valid/ready, rsp_id/data/err;
// busy. Define ULA_SHARE_FLAGS_EN to add rsp_flags {N,Z}.
module ula_share_ctrl
  import ula_pkg::*;
#(
  parameter int NREQ = 2,
  localparam int IDW = $clog2(NREQ)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NREQ-1:0]   req_valid,
  output logic [NREQ-1:0]   req_ready,
  input  logic [4*NREQ-1:0] req_op,
  input  logic [8*NREQ-1:0] req_a,
  input  logic [8*NREQ-1:0] req_b,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [IDW-1:0]    rsp_id,
  output logic [7:0]        rsp_data,
  output logic              rsp_err,
`ifdef ULA_SHARE_FLAGS_EN
  output logic [1:0]        rsp_flags,
`endif
  output logic              busy
);

  state_t          state_q;
  state_t          state_d;
  logic [IDW-1:0]  rr_q;
  logic [IDW-1:0]  rr_nxt;
  logic [NREQ-1:0] win_gnt;
  logic [IDW-1:0]  win_idx;
  logic [IDW-1:0]  id_q;
  ula_op_t         op_q;
  logic [7:0]      a_q;
  logic [7:0]      b_q;
  logic [7:0]      alu_y;
  logic            idle;
  logic            hs;

  ula_rr_arb #(.NREQ(NREQ)) u_arb (
    .req (req_valid),
    .ptr (rr_q),
    .gnt (win_gnt),
    .idx (win_idx)
  );

  ula u_ula (
    .op (op_q),
    .a  (a_q),
    .b  (b_q),
    .y  (alu_y)
  );

  assign idle = (state_q == IDLE);
  assign busy = !idle;

  // Gated by rst so a grant never shows while reset wins.
  assign req_ready = (idle && !rst) ? win_gnt : '0;
  assign hs        = |req_ready;

  assign rr_nxt = (win_idx == IDW'(NREQ - 1))
                ? '0 : win_idx + IDW'(1);

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (hs) state_d = EXEC;
      EXEC:    state_d = HOLD;
      HOLD:    if (rsp_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      rr_q      <= '0;
      id_q      <= '0;
      op_q      <= OP_ADD;
      a_q       <= 8'h00;
      b_q       <= 8'h00;
      rsp_valid <= 1'b0;
      rsp_id    <= '0;
      rsp_data  <= 8'h00;
      rsp_err   <= 1'b0;
`ifdef ULA_SHARE_FLAGS_EN
      rsp_flags <= 2'b00;
`endif
    end else begin
      state_q <= state_d;
      if (hs) begin
        op_q <= req_op[win_idx*4 +: 4];
        a_q  <= req_a[win_idx*8 +: 8];
        b_q  <= req_b[win_idx*8 +: 8];
        id_q <= win_idx;
        rr_q <= rr_nxt;
      end
      if (state_q == EXEC) begin
        rsp_valid <= 1'b1;
        rsp_id    <= id_q;
        rsp_data  <= alu_y;
        rsp_err   <= !op_is_legal(op_q);
`ifdef ULA_SHARE_FLAGS_EN
        rsp_flags <= {alu_y[7], alu_y == 8'h00};
`endif
      end else if (state_q == HOLD && rsp_ready) begin
        rsp_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_ula_share_ctrl.sv
// tb_ula_share_ctrl: directed + random stimulus, reference
// model pushes expected results, monitor pops and compares.
module tb_ula_share_ctrl;

  localparam int NREQ = 2;
  localparam int IDW  = 1;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic [NREQ-1:0]   req_valid = '0;
  logic [NREQ-1:0]   req_ready;
  logic [4*NREQ-1:0] req_op = '0;
  logic [8*NREQ-1:0] req_a = '0;
  logic [8*NREQ-1:0] req_b = '0;
  logic              rsp_valid;
  logic              rsp_ready = 1'b0;
  logic [IDW-1:0]    rsp_id;
  logic [7:0]        rsp_data;
  logic              rsp_err;
  logic              busy;
`ifdef ULA_SHARE_FLAGS_EN
  logic [1:0]        rsp_flags;
`endif

  ula_share_ctrl #(.NREQ(NREQ)) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_op    (req_op),
    .req_a     (req_a),
    .req_b     (req_b),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_id    (rsp_id),
    .rsp_data  (rsp_data),
    .rsp_err   (rsp_err),
`ifdef ULA_SHARE_FLAGS_EN
    .rsp_flags (rsp_flags),
`endif
    .busy      (busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    int id;
    int data;
    int err;
    int flags;
  } exp_t;

  exp_t sb[$];
  int   n_chk  = 0;
  int   n_pass = 0;

  // Model: 0 free, 1 computing, 2 result offered.
  int   m_phase = 0;
  int   m_ptr   = 0;

  task automatic chk(string nm, int act, int exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", nm, act, exp);
  endtask

  function automatic int pick(logic [NREQ-1:0] v, int p);
    for (int k = 0; k < NREQ; k++) begin
      int c;
      c = (p + k) % NREQ;
      if (v[c]) return c;
    end
    return -1;
  endfunction

  function automatic exp_t ref_op(int id, int op, int a, int b);
    exp_t e;
    int   d;
    case (op)
      0:       d = (a + b) % 256;
      1:       d = (a - b + 256) % 256;
      2:       d = a & b;
      3:       d = a | b;
      default: d = 0;
    endcase
    e.id    = id;
    e.data  = d;
    e.err   = (op > 3) ? 1 : 0;
    e.flags = ((d >= 128) ? 2 : 0) + ((d == 0) ? 1 : 0);
    return e;
  endfunction

  // Reference model, sampled mid-cycle.
  always @(negedge clk) begin
    int w;
    logic [NREQ-1:0] er;
    er = '0;
    w  = -1;
    if (!rst && m_phase == 0) begin
      w = pick(req_valid, m_ptr);
      if (w >= 0) er[w] = 1'b1;
    end
    chk("req_ready", int'(req_ready), int'(er));
    chk("busy", int'(busy), (m_phase != 0) ? 1 : 0);
    chk("rsp_valid", int'(rsp_valid), (m_phase == 2) ? 1 : 0);
    if (rst) begin
      m_phase = 0;
      m_ptr   = 0;
      sb.delete();
    end else begin
      case (m_phase)
        0: if (w >= 0) begin
          sb.push_back(ref_op(w, int'(req_op[4*w +: 4]),
                              int'(req_a[8*w +: 8]),
                              int'(req_b[8*w +: 8])));
          m_ptr   = (w + 1) % NREQ;
          m_phase = 1;
        end
        1: m_phase = 2;
        default: if (rsp_ready) m_phase = 0;
      endcase
    end
  end

  // Monitor: compare offered result with scoreboard head.
  always @(negedge clk) begin
    if (!rst && rsp_valid) begin
      if (sb.size() == 0) begin
        chk("rsp_unexpected", 1, 0);
      end else begin
        chk("rsp_id", int'(rsp_id), sb[0].id);
        chk("rsp_data", int'(rsp_data), sb[0].data);
        chk("rsp_err", int'(rsp_err), sb[0].err);
`ifdef ULA_SHARE_FLAGS_EN
        chk("rsp_flags", int'(rsp_flags), sb[0].flags);
`endif
        if (rsp_ready) void'(sb.pop_front());
      end
    end
  end

  task automatic set_req(int i, int op, int a, int b);
    req_op[4*i +: 4] = op[3:0];
    req_a[8*i +: 8]  = a[7:0];
    req_b[8*i +: 8]  = b[7:0];
  endtask

  // Call at posedge+1; returns at posedge+1 after handshake.
  task automatic issue(int i, int op, int a, int b);
    bit got;
    set_req(i, op, a, b);
    req_valid    = '0;
    req_valid[i] = 1'b1;
    got = 1'b0;
    for (int t = 0; t < 40 && !got; t++) begin
      @(negedge clk);
      if (req_ready[i]) got = 1'b1;
    end
    chk("issue_timeout", int'(got), 1);
    @(posedge clk);
    #1;
    req_valid = '0;
  endtask

  task automatic wait_idle();
    bit done;
    done = 1'b0;
    rsp_ready = 1'b1;
    for (int t = 0; t < 40 && !done; t++) begin
      @(negedge clk);
      if (!busy && !rsp_valid && sb.size() == 0) done = 1'b1;
    end
    chk("idle_timeout", int'(done), 1);
    @(posedge clk);
    #1;
  endtask

  initial begin
    req_valid = '1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_outputs",
        int'({rsp_valid, rsp_id, rsp_data, rsp_err, busy}), 0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    chk("first_ready", int'(req_ready), 1);
    @(posedge clk);
    #1;
    req_valid = '0;
    wait_idle();

    issue(0, 0, 'h7F, 'h01);
    wait_idle();
    issue(0, 1, 'h00, 'h01);
    wait_idle();

    set_req(0, 0, 'h11, 'h22);
    set_req(1, 1, 'h10, 'h20);
    req_valid = '1;
    repeat (24) @(posedge clk);
    #1;
    req_valid = '0;
    wait_idle();

    rsp_ready = 1'b0;
    issue(1, 2, 'hF0, 'h3C);
    req_valid = '1;
    repeat (7) @(posedge clk);
    #1;
    req_valid = '0;
    rsp_ready = 1'b1;
    wait_idle();

    issue(0, 9, 'h12, 'h34);
    wait_idle();

    issue(1, 0, 'h05, 'h06);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    chk("rst_exec_valid", int'(rsp_valid), 0);
    chk("rst_exec_busy", int'(busy), 0);
    @(posedge clk);
    #1;
    req_valid = '1;
    @(negedge clk);
    chk("rr_after_rst", int'(req_ready), 1);
    @(posedge clk);
    #1;
    req_valid = '0;
    wait_idle();

    issue(0, 3, 'h00, 'h00);
    wait_idle();
    issue(0, 3, 'h80, 'h00);
    wait_idle();

    repeat (1500) begin
      @(posedge clk);
      #1;
      for (int i = 0; i < NREQ; i++) begin
        int op;
        op = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 15)
                                         : $urandom_range(0, 3);
        set_req(i, op, $urandom_range(0, 255),
                $urandom_range(0, 255));
      end
      req_valid = NREQ'($urandom);
      rsp_ready = ($urandom_range(0, 3) != 0);
      rst       = ($urandom_range(0, 199) == 0);
    end
    @(posedge clk);
    #1;
    rst = 1'b0;
    req_valid = '0;
    wait_idle();
    chk("sb_drain", sb.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
